// File: rtl/mem_stage_cached.sv
// Pipeline MEM stage: direct-mapped write-through cache (no write allocate) in front of
// a req/ack backing memory, plus the sprite/ALU result mux and branch evaluator.
module mem_stage_cached #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 22,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] sprite_data,
  input  logic              sprite_alu_select,
  input  logic              flag_ov,
  input  logic              flag_neg,
  input  logic              flag_zero,
  input  logic [2:0]        branch_condition,
  output logic              stall,
  output logic              rd_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic              cache_hit,
  output logic [DATA_W-1:0] sprite_alu_result,
  output logic              branch_taken,
  output logic              bm_req,
  output logic              bm_we,
  output logic [ADDR_W-1:0] bm_addr,
  output logic [DATA_W-1:0] bm_wdata,
  input  logic              bm_ack,
  input  logic [DATA_W-1:0] bm_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
  state_t state, state_next;

  logic [LINES-1:0]   line_valid;
  logic [TAG_W-1:0]   line_tag  [LINES];
  logic [DATA_W-1:0]  line_data [LINES];

  logic [INDEX_W-1:0] index, bm_index;
  logic [TAG_W-1:0]   tag;
  logic               lookup_hit, wr_hit;
  logic               load_hit, load_miss, store_start, rd_fill, wr_done;

  assign index      = addr[INDEX_W-1:0];
  assign tag        = addr[ADDR_W-1:INDEX_W];
  assign bm_index   = bm_addr[INDEX_W-1:0];
  assign lookup_hit = line_valid[index] && (line_tag[index] == tag);

  assign store_start = (state == IDLE) && we;
  assign load_hit    = (state == IDLE) && !we && re && lookup_hit;
  assign load_miss   = (state == IDLE) && !we && re && !lookup_hit;
  assign rd_fill     = (state == RD_MISS) && bm_ack;
  assign wr_done     = (state == WR_THRU) && bm_ack;

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (we) begin
          stall      = 1'b1;
          state_next = WR_THRU;
        end else if (re && !lookup_hit) begin
          stall      = 1'b1;
          state_next = RD_MISS;
        end
      end
      RD_MISS, WR_THRU: begin
        stall = !bm_ack;
        if (bm_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      line_valid <= '0;
      rd_valid   <= 1'b0;
      cache_hit  <= 1'b0;
      mem_result <= '0;
      bm_req     <= 1'b0;
      bm_we      <= 1'b0;
      bm_addr    <= '0;
      bm_wdata   <= '0;
      wr_hit     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state     <= state_next;
      rd_valid  <= load_hit || rd_fill;
      cache_hit <= load_hit;
      if (load_hit) mem_result <= line_data[index];
      if (rd_fill) begin
        mem_result           <= bm_rdata;
        line_valid[bm_index] <= 1'b1;
      end
      if (store_start) begin
        bm_addr  <= addr;
        bm_wdata <= wr_data;
        bm_req   <= 1'b1;
        bm_we    <= 1'b1;
        wr_hit   <= lookup_hit;
      end else if (load_miss) begin
        bm_addr <= addr;
        bm_req  <= 1'b1;
        bm_we   <= 1'b0;
      end
      if (rd_fill || wr_done) begin
        bm_req <= 1'b0;
        bm_we  <= 1'b0;
      end
      if (load_hit && (hit_count != '1)) hit_count <= hit_count + 1'b1;
      if (load_miss && (miss_count != '1)) miss_count <= miss_count + 1'b1;
    end
  end

  // Tag/data storage carries no reset; only the valid bits need clearing.
  always_ff @(posedge clk) begin
    if (rd_fill) begin
      line_tag[bm_index]  <= bm_addr[ADDR_W-1:INDEX_W];
      line_data[bm_index] <= bm_rdata;
    end else if (wr_done && wr_hit) begin
      line_data[bm_index] <= bm_wdata;
    end
  end

  assign sprite_alu_result = sprite_alu_select ? sprite_data : alu_result;

  always_comb begin
    branch_taken = 1'b0;
    case (branch_condition)
      3'b000: branch_taken = !flag_zero;
      3'b001: branch_taken = flag_zero;
      3'b010: branch_taken = !flag_zero && !flag_neg;
      3'b011: branch_taken = flag_neg;
      3'b100: branch_taken = !flag_neg;
      3'b101: branch_taken = flag_neg || flag_zero;
      3'b110: branch_taken = flag_ov;
      3'b111: branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_mem_stage_cached.sv
// Directed bench for mem_stage_cached: loads, stores, conflicts, reset, branch and mux.
module tb_mem_stage_cached;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re = 1'b0, we = 1'b0;
  logic [21:0] addr = '0;
  logic [31:0] wr_data = '0, alu_result = '0, sprite_data = '0;
  logic        sprite_alu_select = 1'b0;
  logic        flag_ov = 1'b0, flag_neg = 1'b0, flag_zero = 1'b0;
  logic [2:0]  branch_condition = '0;
  logic        stall, rd_valid, cache_hit, branch_taken, bm_req, bm_we;
  logic [31:0] mem_result, sprite_alu_result, bm_wdata;
  logic [21:0] bm_addr;
  logic        bm_ack = 1'b0;
  logic [31:0] bm_rdata = '0;
  logic [2:0]  hit_count, miss_count;

  int tests = 0;
  int fails = 0;

  mem_stage_cached #(.DATA_W(32), .ADDR_W(22), .INDEX_W(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wr_data(wr_data),
    .alu_result(alu_result), .sprite_data(sprite_data),
    .sprite_alu_select(sprite_alu_select), .flag_ov(flag_ov), .flag_neg(flag_neg),
    .flag_zero(flag_zero), .branch_condition(branch_condition), .stall(stall),
    .rd_valid(rd_valid), .mem_result(mem_result), .cache_hit(cache_hit),
    .sprite_alu_result(sprite_alu_result), .branch_taken(branch_taken),
    .bm_req(bm_req), .bm_we(bm_we), .bm_addr(bm_addr), .bm_wdata(bm_wdata),
    .bm_ack(bm_ack), .bm_rdata(bm_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request held until stall drops; the backing memory acks after `delay` busy cycles.
  task automatic access(input logic r, input logic w, input logic [21:0] a,
                        input logic [31:0] wd, input int delay, input logic [31:0] rdata,
                        output int stalls, output logic saw_we,
                        output logic [21:0] saw_addr, output logic [31:0] saw_wdata);
    int waited;
    bit seen;
    bit done;
    @(posedge clk); #1;
    re = r; we = w; addr = a; wr_data = wd;
    stalls = 0; waited = 0; seen = 0; done = 0;
    saw_we = 1'b0; saw_addr = '0; saw_wdata = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bm_req) begin
        if (!seen) begin
          seen = 1; saw_we = bm_we; saw_addr = bm_addr; saw_wdata = bm_wdata;
        end
        if (waited == delay) begin
          bm_ack = 1'b1; bm_rdata = rdata;
        end else begin
          waited++;
        end
      end
      #1;
      if (stall) stalls++;
      else done = 1;
    end
    check("access_done", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0; bm_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          st;
    logic        swe;
    logic [21:0] sa;
    logic [31:0] sw;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_bm_req", bm_req, 0);
    check("rst_mem_result", mem_result, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);

    // Cold load
    access(1, 0, 22'h000005, 0, 3, 32'hDEADBEEF, st, swe, sa, sw);
    check("cold_stalls", st, 4);
    check("cold_bm_addr", sa, 22'h000005);
    check("cold_bm_we", swe, 0);
    check("cold_rd_valid", rd_valid, 1);
    check("cold_hit", cache_hit, 0);
    check("cold_data", mem_result, 32'hDEADBEEF);
    check("cold_misses", miss_count, 1);
    @(negedge clk);
    check("pulse_rd_valid", rd_valid, 0);

    // Reload hits
    access(1, 0, 22'h000005, 0, 0, 0, st, swe, sa, sw);
    check("hit_stalls", st, 0);
    check("hit_rd_valid", rd_valid, 1);
    check("hit_flag", cache_hit, 1);
    check("hit_data", mem_result, 32'hDEADBEEF);
    check("hit_count1", hit_count, 1);

    // Conflict on index 5
    access(1, 0, 22'h000015, 0, 1, 32'hCAFEF00D, st, swe, sa, sw);
    check("conf_stalls", st, 2);
    check("conf_hit", cache_hit, 0);
    check("conf_data", mem_result, 32'hCAFEF00D);
    access(1, 0, 22'h000005, 0, 2, 32'hDEADBEEF, st, swe, sa, sw);
    check("conf2_hit", cache_hit, 0);
    check("conf2_misses", miss_count, 3);
    access(1, 0, 22'h000015, 0, 0, 32'hCAFEF00D, st, swe, sa, sw);
    check("conf3_stalls", st, 1);
    check("conf3_misses", miss_count, 4);

    // Store hit updates the line
    access(0, 1, 22'h000015, 32'h12345678, 2, 0, st, swe, sa, sw);
    check("st_stalls", st, 3);
    check("st_bm_we", swe, 1);
    check("st_bm_addr", sa, 22'h000015);
    check("st_bm_wdata", sw, 32'h12345678);
    check("st_rd_valid", rd_valid, 0);
    check("st_bm_req_off", bm_req, 0);
    access(1, 0, 22'h000015, 0, 0, 0, st, swe, sa, sw);
    check("sthit_stalls", st, 0);
    check("sthit_flag", cache_hit, 1);
    check("sthit_data", mem_result, 32'h12345678);
    check("sthit_hits", hit_count, 2);

    // Store miss does not allocate
    access(0, 1, 22'h000020, 32'hAAAA5555, 1, 0, st, swe, sa, sw);
    check("stm_misses", miss_count, 4);
    access(1, 0, 22'h000020, 0, 1, 32'h0BADCAFE, st, swe, sa, sw);
    check("noalloc_hit", cache_hit, 0);
    check("noalloc_data", mem_result, 32'h0BADCAFE);
    check("noalloc_misses", miss_count, 5);

    // re and we together: write only
    access(1, 1, 22'h000007, 32'h00000055, 1, 32'hFFFFFFFF, st, swe, sa, sw);
    check("rw_bm_we", swe, 1);
    check("rw_bm_wdata", sw, 32'h00000055);
    check("rw_rd_valid", rd_valid, 0);
    check("rw_hits", hit_count, 2);
    check("rw_misses", miss_count, 5);

    // Miss counter saturates at 7 (CNT_W = 3)
    access(1, 0, 22'h000030, 0, 0, 32'h30, st, swe, sa, sw);
    access(1, 0, 22'h000040, 0, 0, 32'h40, st, swe, sa, sw);
    check("sat_misses7", miss_count, 7);
    access(1, 0, 22'h000050, 0, 0, 32'h50, st, swe, sa, sw);
    check("sat_misses_hold", miss_count, 7);
    check("sat_data", mem_result, 32'h50);

    // Branch evaluator and result mux
    flag_neg = 0; flag_zero = 0; flag_ov = 0;
    branch_condition = 3'b010; #1 check("br_gt", branch_taken, 1);
    branch_condition = 3'b100; #1 check("br_gte", branch_taken, 1);
    branch_condition = 3'b011; #1 check("br_lt", branch_taken, 0);
    branch_condition = 3'b111; #1 check("br_uncond", branch_taken, 1);
    flag_ov = 1; branch_condition = 3'b110; #1 check("br_ovfl", branch_taken, 1);
    flag_ov = 0; flag_zero = 1; branch_condition = 3'b000; #1 check("br_neq", branch_taken, 0);
    branch_condition = 3'b101; #1 check("br_lte", branch_taken, 1);
    alu_result = 32'h11112222; sprite_data = 32'h33334444;
    sprite_alu_select = 1; #1 check("mux_sprite", sprite_alu_result, 32'h33334444);
    sprite_alu_select = 0; #1 check("mux_alu", sprite_alu_result, 32'h11112222);

    // Reset in the middle of a read miss
    @(posedge clk); #1;
    re = 1'b1; addr = 22'h000009;
    @(posedge clk); #1;
    check("mid_bm_req", bm_req, 1);
    @(posedge clk); #1;
    rst = 1'b1; re = 1'b0;
    #1;
    check("mrst_bm_req", bm_req, 0);
    check("mrst_bm_we", bm_we, 0);
    check("mrst_bm_addr", bm_addr, 0);
    check("mrst_rd_valid", rd_valid, 0);
    check("mrst_mem_result", mem_result, 0);
    check("mrst_hits", hit_count, 0);
    check("mrst_misses", miss_count, 0);
    check("mrst_stall", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0; bm_ack = 1'b1; bm_rdata = 32'h77777777;
    @(posedge clk); #1;
    bm_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_rd_valid", rd_valid, 0);
    check("stray_ack_bm_req", bm_req, 0);
    access(1, 0, 22'h000005, 0, 1, 32'h5A5A5A5A, st, swe, sa, sw);
    check("post_rst_stalls", st, 2);
    check("post_rst_hit", cache_hit, 0);
    check("post_rst_data", mem_result, 32'h5A5A5A5A);
    check("post_rst_misses", miss_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
